// File: rtl/knn_pkg.sv
// Shared widths and FSM encoding for the k-nearest-neighbour distance core.
package knn_pkg;

  localparam int KNN_DATA_W  = 32;
  localparam int KNN_COORD_W = KNN_DATA_W / 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_LOAD = 3'd2,
    ST_CALC = 3'd3,
    ST_DONE = 3'd4
  } knn_state_e;

endpackage

// File: rtl/knn_sqdiff.sv
// Combinational squared absolute difference of one unsigned coordinate pair.
module knn_sqdiff
  import knn_pkg::*;
#(
  parameter int COORD_W = KNN_COORD_W
) (
  input  logic [COORD_W-1:0]   a,
  input  logic [COORD_W-1:0]   b,
  output logic [2*COORD_W-1:0] sq
);

  logic [COORD_W-1:0] diff;

  always_comb begin
    diff = (a >= b) ? (a - b) : (b - a);
  end

  // Zero-extend before multiplying so the full 2*COORD_W product is kept.
  assign sq = {{COORD_W{1'b0}}, diff} * {{COORD_W{1'b0}}, diff};

endmodule

// File: rtl/knn_core.sv
// Loads Ax, Bx, Ay, By serially and produces a saturated squared Euclidean
// distance; KNN_VALUE is a separately sampled copy of the result register.
module knn_core
  import knn_pkg::*;
#(
  parameter int DATA_W = KNN_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              KNN_ENABLE,
  input  logic              KNN_SAMPLE,
  input  logic [DATA_W-1:0] KNN_DATA_IN,
  output logic [DATA_W-1:0] KNN_VALUE
);

  localparam int CW = DATA_W / 2;

  knn_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [CW-1:0]     ax_q, ax_d, bx_q, bx_d, ay_q, ay_d, by_q, by_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] value_q, value_d;

  logic [CW-1:0]     word;
  logic [DATA_W-1:0] sq_x, sq_y;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] sat;
  logic              data_hi_unused;

  assign word           = KNN_DATA_IN[CW-1:0];
  assign data_hi_unused = ^KNN_DATA_IN[DATA_W-1:CW];

  knn_sqdiff #(.COORD_W(CW)) u_sq_x (.a(ax_q), .b(bx_q), .sq(sq_x));
  knn_sqdiff #(.COORD_W(CW)) u_sq_y (.a(ay_q), .b(by_q), .sq(sq_y));

  assign sum = {1'b0, sq_x} + {1'b0, sq_y};
  assign sat = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ax_d     = ax_q;
    bx_d     = bx_q;
    ay_d     = ay_q;
    by_d     = by_q;
    result_d = result_q;
    value_d  = KNN_SAMPLE ? result_q : value_q;

    case (state_q)
      ST_IDLE: begin
        if (KNN_ENABLE) state_d = ST_ARM;
      end
      // ARM always has cnt_q == 0, so its capture edge stores Ax.
      ST_ARM, ST_LOAD: begin
        if (!KNN_ENABLE) begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
          ax_d    = '0;
          bx_d    = '0;
          ay_d    = '0;
          by_d    = '0;
        end else begin
          case (cnt_q)
            2'd0:    ax_d = word;
            2'd1:    bx_d = word;
            2'd2:    ay_d = word;
            default: by_d = word;
          endcase
          if (cnt_q == 2'd3) begin
            state_d = ST_CALC;
            cnt_d   = 2'd0;
          end else begin
            state_d = ST_LOAD;
            cnt_d   = cnt_q + 2'd1;
          end
        end
      end
      ST_CALC: begin
        if (!KNN_ENABLE) begin
          state_d = ST_IDLE;
          ax_d    = '0;
          bx_d    = '0;
          ay_d    = '0;
          by_d    = '0;
        end else begin
          result_d = sat;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!KNN_ENABLE) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      ax_q     <= '0;
      bx_q     <= '0;
      ay_q     <= '0;
      by_q     <= '0;
      result_q <= '0;
      value_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ax_q     <= ax_d;
      bx_q     <= bx_d;
      ay_q     <= ay_d;
      by_q     <= by_d;
      result_q <= result_d;
      value_q  <= value_d;
    end
  end

  assign KNN_VALUE = value_q;

endmodule

// File: tb/tb_knn_core.sv
// Randomised scoreboard bench for knn_core: stimulus queues expected KNN_VALUE
// for every sample/reset edge, a monitor pops and compares after that edge.
module tb_knn_core;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sample;
  logic [31:0] data;
  logic [31:0] value;

  int cnt_cmp;
  int cnt_err;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] model_result;

  knn_core #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .KNN_ENABLE (en),
    .KNN_SAMPLE (sample),
    .KNN_DATA_IN(data),
    .KNN_VALUE  (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_dist(input longint ax, input longint bx,
                                           input longint ay, input longint by);
    longint dx, dy, s;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    s  = dx * dx + dy * dy;
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
    return s[31:0];
  endfunction

  task automatic push_exp(input logic [31:0] v, input string nm);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic do_sample(input string nm);
    @(negedge clk);
    sample = 1'b1;
    push_exp(model_result, nm);
    @(negedge clk);
    sample = 1'b0;
  endtask

  task automatic run_seq(input logic [15:0] ax, input logic [15:0] bx,
                         input logic [15:0] ay, input logic [15:0] by,
                         input bit samp_calc, input int hold);
    @(negedge clk); en = 1'b1; data = $urandom;
    @(negedge clk); data = {16'($urandom), ax};
    @(negedge clk); data = {16'($urandom), bx};
    @(negedge clk); data = {16'($urandom), ay};
    @(negedge clk); data = {16'($urandom), by};
    @(negedge clk); data = $urandom;
    if (samp_calc) begin
      sample = 1'b1;
      push_exp(model_result, "same_edge_old");
    end
    model_result = ref_dist(longint'(ax), longint'(bx), longint'(ay), longint'(by));
    @(negedge clk); sample = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      data = $urandom;
    end
    @(negedge clk); en = 1'b0;
    @(negedge clk);
  endtask

  task automatic abort_seq(input int nwords);
    @(negedge clk); en = 1'b1; data = $urandom;
    repeat (nwords) begin
      @(negedge clk);
      data = $urandom;
    end
    @(negedge clk); en = 1'b0; data = $urandom;
    @(negedge clk);
  endtask

  // Monitor: any edge with KNN_SAMPLE or rst high defines a new KNN_VALUE.
  initial begin
    bit          chk;
    logic [31:0] e;
    string       nm;
    forever begin
      @(posedge clk);
      chk = sample || rst;
      @(negedge clk);
      if (chk) begin
        cnt_cmp++;
        if (exp_q.size() == 0) begin
          cnt_err++;
          $display("FAIL no_expected: KNN_VALUE=%h with empty scoreboard", value);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (value !== e) begin
            cnt_err++;
            $display("FAIL %s: KNN_VALUE=%h required=%h", nm, value, e);
          end else begin
            $display("ok   %s: KNN_VALUE=%h", nm, value);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    cnt_cmp      = 0;
    cnt_err      = 0;
    model_result = 32'h0;
    rst          = 1'b1;
    en           = 1'b0;
    sample       = 1'b0;
    data         = 32'h0;
    push_exp(32'h0, "reset_0");
    push_exp(32'h0, "reset_1");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_sample("pre_sequence");
    run_seq(16'd4, 16'd3, 16'd2, 16'd1, 1'b0, 2);
    do_sample("seq_4321");
    run_seq(16'd3, 16'd4, 16'd1, 16'd2, 1'b0, 0);
    do_sample("abs_diff_3412");
    run_seq(16'hFFFF, 16'h0, 16'hFFFF, 16'h0, 1'b1, 5);
    do_sample("saturate");

    abort_seq(2);
    do_sample("after_abort");
    run_seq(16'd10, 16'd7, 16'd5, 16'd1, 1'b0, 1);
    do_sample("seq_10_7_5_1");

    // Held sample re-copies the result each cycle.
    @(negedge clk);
    sample = 1'b1;
    push_exp(model_result, "multi_sample_0");
    @(negedge clk); push_exp(model_result, "multi_sample_1");
    @(negedge clk); push_exp(model_result, "multi_sample_2");
    @(negedge clk); sample = 1'b0;

    // Reset in the middle of a load clears everything.
    @(negedge clk); en = 1'b1;
    @(negedge clk); data = 32'd9;
    @(negedge clk); data = 32'd8;
    @(negedge clk);
    rst = 1'b1; en = 1'b0; sample = 1'b1;
    push_exp(32'h0, "reset_mid_load");
    model_result = 32'h0;
    @(negedge clk); rst = 1'b0; sample = 1'b0;
    do_sample("after_reset");
    run_seq(16'd4, 16'd3, 16'd2, 16'd1, 1'b0, 0);
    do_sample("post_reset_4321");

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        abort_seq(int'($urandom_range(0, 4)));
        do_sample($sformatf("rand_abort_%0d", i));
      end else begin
        logic [15:0] c[4];
        bit big;
        big = ($urandom_range(0, 3) == 0);
        for (int k = 0; k < 4; k++) begin
          c[k] = 16'($urandom);
          if (big) c[k] = (k % 2 == 0) ? (16'hC000 | c[k]) : (c[k] & 16'h1FFF);
        end
        run_seq(c[0], c[1], c[2], c[3], bit'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
        do_sample($sformatf("rand_seq_%0d", i));
      end
    end

    repeat (3) @(negedge clk);
    cnt_cmp++;
    if (exp_q.size() != 0) begin
      cnt_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_err);
    $finish;
  end

endmodule

// File: doc/knn_core.md
KNN_CORE -- requirements
Module: knn_core

Interface
REQ-001 Parameter DATA_W, default 32: width of data input and result; coordinates use the low DATA_W/2 bits.
REQ-002 clk  in  1  single system clock; all logic updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 KNN_ENABLE  in  1  high arms and runs a load/compute sequence; low aborts it and returns to idle.
REQ-005 KNN_SAMPLE  in  1  single-cycle pulse copying the internal result to KNN_VALUE.
REQ-006 KNN_DATA_IN  in  DATA_W  coordinate word; only bits [DATA_W/2-1:0] are used, unsigned.
REQ-007 KNN_VALUE  out  DATA_W  registered squared Euclidean distance, updated only on a sample.

Function
REQ-008 FSM states: IDLE, ARM, LOAD, CALC, DONE.
REQ-009 IDLE -> ARM on a clock edge with KNN_ENABLE=1; no word is captured in that cycle.
REQ-010 ARM -> LOAD on the next edge with KNN_ENABLE=1; the word present at that edge is captured as Ax.
REQ-011 LOAD captures one word per clock while enabled, in order Ax, Bx, Ay, By; 2-bit word counter.
REQ-012 After By is captured, LOAD -> CALC; CALC computes the result in one cycle, then -> DONE.
REQ-013 result = (|Ax-Bx|)^2 + (|Ay-By|)^2, with each term DATA_W bits and a DATA_W+1-bit sum.
REQ-014 If the sum exceeds 2^DATA_W-1, result saturates to all ones.
REQ-015 Latency: result register valid on the edge after the By capture edge; KNN_VALUE follows on the next sample.
REQ-016 DONE holds while KNN_ENABLE=1; KNN_ENABLE=0 -> IDLE; a new sequence needs KNN_ENABLE to go low and then high again.
REQ-017 KNN_ENABLE=0 in ARM, LOAD or CALC -> IDLE, counter cleared, captured words discarded, result register unchanged.
REQ-018 On an edge with KNN_SAMPLE=1, KNN_VALUE <= result register; KNN_SAMPLE is honoured in every state and is independent of KNN_ENABLE.
REQ-019 If KNN_SAMPLE=1 on the same edge the result register updates, KNN_VALUE takes the old result value.
REQ-020 Multi-cycle KNN_SAMPLE re-copies the result each cycle; no other side effect.

Reset
REQ-021 rst=1 at a clock edge: state IDLE, counter 0, coordinate registers 0, result register 0, KNN_VALUE 0.
REQ-022 rst overrides KNN_ENABLE and KNN_SAMPLE on the same edge.
REQ-023 rst mid-sequence aborts the sequence; a new sequence needs KNN_ENABLE=1 after reset is released.

Structure
REQ-024 Shared package holds DATA_W, the coordinate width DATA_W/2 and the FSM state encoding.
REQ-025 One sub-module, knn_sqdiff: combinational |a-b|^2 for a coordinate pair; two instances feed the saturating adder.
REQ-026 All other logic (FSM, capture registers, result register and output register) is in knn_core; there is no other state.

Verification
REQ-027 Enable, one arm cycle, then 4,3,2,1; wait; pulse sample -> KNN_VALUE = 2.
REQ-028 Words 3,4,1,2 (Ax<Bx, Ay<By) -> KNN_VALUE = 2, checking the absolute difference.
REQ-029 Words 0xFFFF,0,0xFFFF,0 at DATA_W=32 -> KNN_VALUE = 0xFFFFFFFF (saturated).
REQ-030 Sample pulse before any sequence completes -> KNN_VALUE = 0.
REQ-031 Drop KNN_ENABLE after two words, re-enable, then load 10,7,5,1 -> KNN_VALUE = 25; the partial load has no effect.
REQ-032 Assert rst during LOAD, then a sample pulse -> KNN_VALUE = 0; the following full sequence 4,3,2,1 -> 2.
